// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bus bundle between the fetch stage and its neighbours.
//   Instruction-memory request/response, decode-side instruction handshake
//   with pre-split opcode fields, branch redirect, and the delivered-count.
//   master: fetch unit side.  slave: memory / decode / control side.
interface fetch_unit_if #(
  parameter int XLEN = 64
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;
  logic [6:0]      op;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic [31:0]     fetch_count;

  modport master (
    output imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
           op, f3, f7, fetch_count,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready,
           redirect, redirect_target
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
           op, f3, f7, fetch_count,
    output imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready,
           redirect, redirect_target
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
//   Holds the PC, issues one word request at a time to instruction memory,
//   and presents the fetched word (plus op/f3/f7 slices) to decode through a
//   single-entry output register. A redirect squashes whatever is in flight
//   or held and restarts fetching at the (word-aligned) target.
// Ports:
//   clk   - clock, all state on the rising edge
//   reset - synchronous active-high reset
//   bus   - fetch_unit_if.master: imem request/response, decode handshake,
//           redirect/redirect_target, fetch_count
module fetch_unit #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]      state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inflightPc;
  logic [XLEN-1:0] instrPc;
  logic [31:0]     instrWord;
  logic            instrValid;
  logic            drop;
  logic [31:0]     fetchCount;

  logic [XLEN-1:0] alignedTarget;
  logic [XLEN-1:0] pcPlus4;
  logic            reqValid;
  logic            reqFire;
  logic            handshake;

  // Low two target bits are ignored so the PC always stays word aligned.
  assign alignedTarget = bus.redirect_target & {{(XLEN-2){1'b1}}, 2'b00};
  assign pcPlus4       = pc + {{(XLEN-3){1'b0}}, 3'b100};

  // Request is only offered from REQ, and never in a redirect or reset cycle.
  always_comb begin
    reqValid = 1'b0;
    if ((state == ST_REQ) && !bus.redirect && !reset) begin
      reqValid = 1'b1;
    end else begin
      reqValid = 1'b0;
    end
  end

  // Decode handshake is void while a redirect is present.
  always_comb begin
    handshake = 1'b0;
    if (instrValid && bus.instr_ready && !bus.redirect) begin
      handshake = 1'b1;
    end else begin
      handshake = 1'b0;
    end
  end

  assign reqFire = reqValid && bus.imem_req_ready;

  // Fetch FSM, PC, output register and delivered-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_REQ;
      pc         <= RESET_PC;
      inflightPc <= '0;
      drop       <= 1'b0;
      instrValid <= 1'b0;
      instrWord  <= 32'h0000_0000;
      instrPc    <= '0;
      fetchCount <= 32'd0;
    end else begin
      case (state)
        ST_REQ: begin
          // Responses are not expected here; a stale one is simply ignored.
          if (bus.redirect) begin
            pc <= alignedTarget;
          end else if (reqFire) begin
            inflightPc <= pc;
            pc         <= pcPlus4;
            state      <= ST_WAIT;
          end else begin
            state <= ST_REQ;
          end
        end
        ST_WAIT: begin
          if (bus.redirect) begin
            pc <= alignedTarget;
            if (bus.imem_resp_valid) begin
              // The response for the squashed fetch arrived this very cycle.
              drop  <= 1'b0;
              state <= ST_REQ;
            end else begin
              // Remember to throw away the response still on its way.
              drop <= 1'b1;
            end
          end else if (bus.imem_resp_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= ST_REQ;
            end else begin
              instrWord  <= bus.imem_resp_data;
              instrPc    <= inflightPc;
              instrValid <= 1'b1;
              state      <= ST_HOLD;
            end
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (bus.redirect) begin
            instrValid <= 1'b0;
            pc         <= alignedTarget;
            state      <= ST_REQ;
          end else if (handshake) begin
            instrValid <= 1'b0;
            fetchCount <= fetchCount + 32'd1;
            state      <= ST_REQ;
          end else begin
            state <= ST_HOLD;
          end
        end
        default: begin
          state      <= ST_REQ;
          drop       <= 1'b0;
          instrValid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req_valid = reqValid;
  assign bus.imem_addr      = pc;
  assign bus.instr_valid    = instrValid;
  assign bus.instr          = instrWord;
  assign bus.instr_pc       = instrPc;
  assign bus.op             = instrWord[6:0];
  assign bus.f3             = instrWord[14:12];
  assign bus.f7             = instrWord[31:25];
  assign bus.fetch_count    = fetchCount;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the RISC-V core: holds the PC, issues word requests to instruction memory, and presents the fetched instruction plus its pre-split op/f3/f7 fields to the decode/control unit.
- Accepts a redirect (taken branch: control-unit branch output with computed target) and squashes any in-flight or held instruction.
- One outstanding memory request; single-entry output register.

Parameters:
XLEN, 64, PC/address width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_addr  output  XLEN  request byte address (bits [1:0] always 0)
imem_resp_valid  input  1  response data valid (exactly one per accepted request, ≥1 cycle after accept)
imem_resp_data  input  32  instruction word
instr_valid  output  1  instruction available to decode
instr_ready  input  1  decode accepts instruction
instr  output  32  held instruction word
instr_pc  output  XLEN  address of held instruction
op  output  7  instr[6:0]
f3  output  3  instr[14:12]
f7  output  7  instr[31:25]
redirect  input  1  taken branch, 1-cycle pulse or level
redirect_target  input  XLEN  new PC; bits [1:0] ignored (forced 00)
fetch_count  output  32  number of instructions delivered to decode

Behaviour:
- Reset (synchronous, active-high): pc=RESET_PC, state=REQ, drop=0, instr_valid=0, instr=0, instr_pc=0, fetch_count=0. imem_req_valid=0 while reset is high. Reset mid-transaction abandons any outstanding response; a response arriving after reset is treated per state REQ rules below (ignored).
- States: REQ, WAIT, HOLD.
- imem_req_valid = (state==REQ) && !redirect && !reset. imem_addr = pc.
- REQ: on imem_req_valid && imem_req_ready -> inflight_pc<=pc, pc<=pc+4 (mod 2^XLEN), go WAIT. imem_resp_valid is ignored in REQ.
- WAIT: on imem_resp_valid:
  - if drop=1: discard data, drop<=0, go REQ.
  - else: instr<=data, instr_pc<=inflight_pc, instr_valid<=1, go HOLD.
- HOLD: instr_valid=1. The handshake is instr_valid && instr_ready && !redirect. On handshake: instr_valid<=0, fetch_count<=fetch_count+1 (wraps), go REQ. Otherwise hold instr/instr_pc stable.
- op/f3/f7 are combinational slices of the instr register.
- Redirect priority over all other events:
  - REQ: pc<=target&~3; stay REQ. No request is issued that cycle.
  - WAIT: pc<=target&~3. If imem_resp_valid is also high that cycle, discard it and go REQ; else drop<=1 and stay WAIT.
  - HOLD: instr_valid<=0 next cycle, pc<=target&~3, go REQ. A same-cycle instr_ready is void and fetch_count is not incremented.
- Latency: request issued the cycle after entering REQ. instr_valid is high the cycle after the response. Minimum 3 cycles per instruction with zero-wait memory.
- Sequence rule: the PC sequence seen on instr_pc is strictly pc, pc+4, … until a redirect. No instruction fetched before a redirect is ever delivered after it.

Test Plan:
- Reset then ready=1, 1-cycle memory returning 0x00000033 at 0x0 and 0x40000033 at 0x4, instr_ready=1 -> addresses 0x0 then 0x4; op=0110011, f7=0000000 then 0100000; fetch_count=2.
- instr_ready=0 for 5 cycles while holding 0x00003003 -> instr/instr_pc stable, no new imem request, op=0000011 f3=011; release -> count increments once.
- Redirect to 0x103 while in WAIT, response arrives 2 cycles later -> response discarded, next request addr=0x100, delivered instr_pc=0x100.
- Redirect in HOLD with instr_ready=1 the same cycle -> instr_valid=0 next cycle, fetch_count unchanged, next addr=target.
- imem_req_ready=0 for 4 cycles -> imem_req_valid held, imem_addr stable, pc not advanced.
- Reset asserted in WAIT, stale response in first post-reset cycle -> ignored; first request addr=RESET_PC, instr_valid=0.
